// File: rtl/raster_fetch_pkg.sv
// Payload types shared by the raster fetch engine and its triangle stream.
package raster_fetch_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;

    typedef struct packed {
        logic [15:0] sx;
        logic [15:0] sy;
        logic [15:0] tx;
        logic [15:0] ty;
    } transform_t;

endpackage

// File: rtl/raster_fetch_if.sv
// Assembled-triangle valid/ready stream from raster_fetch to the rasterizer.
interface raster_fetch_if #(
    parameter int unsigned INST_W = 8
) ();
    import raster_fetch_pkg::*;

    logic              out_valid;
    logic              out_ready;
    vertex_t           out_v0;
    vertex_t           out_v1;
    vertex_t           out_v2;
    transform_t        out_transform;
    logic [INST_W-1:0] out_inst_id;

    modport master (
        output out_valid, out_v0, out_v1, out_v2, out_transform, out_inst_id,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_v0, out_v1, out_v2, out_transform, out_inst_id,
        output out_ready
    );

endinterface

// File: rtl/raster_fetch.sv
// Walks instances and their triangle buffers, fetches the three vertices of
// every triangle and streams them with the instance transform.
module raster_fetch
    import raster_fetch_pkg::*;
#(
    parameter int unsigned MAX_VERT     = 8192,
    parameter int unsigned MAX_TRI      = 8192,
    parameter int unsigned MAX_INST     = 256,
    parameter int unsigned MAX_VERT_CNT = 4096,
    parameter int unsigned MAX_TRI_CNT  = 4096,
    parameter int unsigned VERT_ADDR_W  = $clog2(MAX_VERT),
    parameter int unsigned TRI_ADDR_W   = $clog2(MAX_TRI),
    parameter int unsigned INST_W       = $clog2(MAX_INST),
    parameter int unsigned VIDX_W       = $clog2(MAX_VERT_CNT),
    parameter int unsigned TIDX_W       = $clog2(MAX_TRI_CNT),
    parameter int unsigned TRI_W        = 3 * VIDX_W,
    parameter int unsigned DESC_LAT     = 3
) (
    input  logic                   clk,
    input  logic                   rst_raster_n,
    input  logic                   start,
    input  logic [INST_W:0]        num_inst,
    output logic                   busy,
    output logic                   done,
    output logic [INST_W-1:0]      inst_id_rd,
    output logic [VERT_ADDR_W-1:0] vert_addr_rd,
    output logic [TRI_ADDR_W-1:0]  tri_addr_rd,
    input  logic [VERT_ADDR_W-1:0] curr_vert_base_in,
    input  logic [VIDX_W-1:0]      curr_vert_count_in,
    input  logic [TRI_ADDR_W-1:0]  curr_tri_base_in,
    input  logic [TIDX_W-1:0]      curr_tri_count_in,
    input  logic [TRI_W-1:0]       idx_tri_in,
    input  vertex_t                vert_in,
    input  transform_t             transform_in,
    raster_fetch_if.master         out_if,
    output logic                   oob_err
);

    localparam int unsigned WAIT_W = (DESC_LAT > 0) ? $clog2(DESC_LAT + 1) : 1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INST_WAIT = 4'd1;
    localparam logic [3:0] S_TRI_ADDR  = 4'd2;
    localparam logic [3:0] S_V0_ADDR   = 4'd3;
    localparam logic [3:0] S_V1_ADDR   = 4'd4;
    localparam logic [3:0] S_V2_ADDR   = 4'd5;
    localparam logic [3:0] S_V_CAP     = 4'd6;
    localparam logic [3:0] S_EMIT      = 4'd7;
    localparam logic [3:0] S_NEXT_INST = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;

    logic [3:0]             state_q,    state_d;
    logic [WAIT_W-1:0]      wait_q,     wait_d;
    logic [INST_W-1:0]      inst_ctr_q, inst_ctr_d;
    logic [TIDX_W-1:0]      tri_ctr_q,  tri_ctr_d;
    logic [VERT_ADDR_W-1:0] vbase_q,    vbase_d;
    logic [VIDX_W-1:0]      vcnt_q,     vcnt_d;
    logic [TRI_ADDR_W-1:0]  tbase_q,    tbase_d;
    logic [TIDX_W-1:0]      tcnt_q,     tcnt_d;
    transform_t             xform_q,    xform_d;
    logic [VIDX_W-1:0]      i0_q, i0_d, i1_q, i1_d, i2_q, i2_d;
    vertex_t                v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
    logic                   oob_q,   oob_d;
    logic                   valid_q, valid_d;
    logic                   tri_more;
    logic                   inst_more;

    always_ff @(posedge clk or negedge rst_raster_n) begin
        if (!rst_raster_n) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            inst_ctr_q <= '0;
            tri_ctr_q  <= '0;
            vbase_q    <= '0;
            vcnt_q     <= '0;
            tbase_q    <= '0;
            tcnt_q     <= '0;
            xform_q    <= '0;
            i0_q       <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            v0_q       <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            oob_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            inst_ctr_q <= inst_ctr_d;
            tri_ctr_q  <= tri_ctr_d;
            vbase_q    <= vbase_d;
            vcnt_q     <= vcnt_d;
            tbase_q    <= tbase_d;
            tcnt_q     <= tcnt_d;
            xform_q    <= xform_d;
            i0_q       <= i0_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            oob_q      <= oob_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state logic; read addresses are combinational from state.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        inst_ctr_d   = inst_ctr_q;
        tri_ctr_d    = tri_ctr_q;
        vbase_d      = vbase_q;
        vcnt_d       = vcnt_q;
        tbase_d      = tbase_q;
        tcnt_d       = tcnt_q;
        xform_d      = xform_q;
        i0_d         = i0_q;
        i1_d         = i1_q;
        i2_d         = i2_q;
        v0_d         = v0_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        oob_d        = oob_q;
        valid_d      = valid_q;
        tri_addr_rd  = '0;
        vert_addr_rd = '0;
        tri_more     = ((TIDX_W+1)'(tri_ctr_q) + (TIDX_W+1)'(1)) < (TIDX_W+1)'(tcnt_q);
        inst_more    = ((INST_W+1)'(inst_ctr_q) + (INST_W+1)'(1)) < num_inst;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    inst_ctr_d = '0;
                    oob_d      = 1'b0;
                    busy_d     = 1'b1;
                    wait_d     = '0;
                    state_d    = (num_inst == '0) ? S_DONE : S_INST_WAIT;
                end
            end
            S_INST_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (wait_q == WAIT_W'(DESC_LAT)) begin
                    wait_d    = '0;
                    vbase_d   = curr_vert_base_in;
                    vcnt_d    = curr_vert_count_in;
                    tbase_d   = curr_tri_base_in;
                    tcnt_d    = curr_tri_count_in;
                    xform_d   = transform_in;
                    tri_ctr_d = '0;
                    state_d   = (curr_tri_count_in == '0) ? S_NEXT_INST : S_TRI_ADDR;
                end
            end
            S_TRI_ADDR: begin
                tri_addr_rd = tbase_q + TRI_ADDR_W'(tri_ctr_q);
                state_d     = S_V0_ADDR;
            end
            S_V0_ADDR: begin
                i0_d         = idx_tri_in[3*VIDX_W-1 -: VIDX_W];
                i1_d         = idx_tri_in[2*VIDX_W-1 -: VIDX_W];
                i2_d         = idx_tri_in[VIDX_W-1:0];
                vert_addr_rd = vbase_q + VERT_ADDR_W'(idx_tri_in[3*VIDX_W-1 -: VIDX_W]);
                state_d      = S_V1_ADDR;
            end
            S_V1_ADDR: begin
                v0_d         = vert_in;
                vert_addr_rd = vbase_q + VERT_ADDR_W'(i1_q);
                state_d      = S_V2_ADDR;
            end
            S_V2_ADDR: begin
                v1_d         = vert_in;
                vert_addr_rd = vbase_q + VERT_ADDR_W'(i2_q);
                state_d      = S_V_CAP;
            end
            S_V_CAP: begin
                v2_d = vert_in;
                // Out-of-range triangles are dropped but still consume a slot.
                if ((i0_q >= vcnt_q) || (i1_q >= vcnt_q) || (i2_q >= vcnt_q)) begin
                    oob_d     = 1'b1;
                    tri_ctr_d = tri_ctr_q + TIDX_W'(1);
                    state_d   = tri_more ? S_TRI_ADDR : S_NEXT_INST;
                end else begin
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_if.out_ready) begin
                    valid_d   = 1'b0;
                    tri_ctr_d = tri_ctr_q + TIDX_W'(1);
                    state_d   = tri_more ? S_TRI_ADDR : S_NEXT_INST;
                end
            end
            S_NEXT_INST: begin
                inst_ctr_d = inst_ctr_q + INST_W'(1);
                wait_d     = '0;
                state_d    = inst_more ? S_INST_WAIT : S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inst_id_rd           = inst_ctr_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign oob_err              = oob_q;
    assign out_if.out_valid     = valid_q;
    assign out_if.out_v0        = v0_q;
    assign out_if.out_v1        = v1_q;
    assign out_if.out_v2        = v2_q;
    assign out_if.out_transform = xform_q;
    assign out_if.out_inst_id   = inst_ctr_q;

endmodule

// File: tb/tb_raster_fetch.sv
// Randomized self-checking bench for raster_fetch with a frame-level reference model.
module tb_raster_fetch;
    import raster_fetch_pkg::*;

    localparam int unsigned INST_W = 8;
    localparam int unsigned VA_W   = 13;
    localparam int unsigned TA_W   = 13;
    localparam int unsigned VIDX_W = 12;
    localparam int unsigned TIDX_W = 12;
    localparam int unsigned TRI_W  = 36;
    localparam int unsigned NV     = 8192;
    localparam int unsigned NT     = 8192;

    typedef struct packed {
        vertex_t           v0;
        vertex_t           v1;
        vertex_t           v2;
        transform_t        xf;
        logic [INST_W-1:0] inst;
    } tri_rec_t;

    localparam int unsigned SNAP_W = 4 + INST_W + TA_W + VA_W + $bits(tri_rec_t);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [INST_W:0]   num_inst = '0;
    logic              busy, done, oob_err;
    logic [INST_W-1:0] inst_id_rd;
    logic [VA_W-1:0]   vert_addr_rd;
    logic [TA_W-1:0]   tri_addr_rd;
    logic [VA_W-1:0]   curr_vert_base_in;
    logic [VIDX_W-1:0] curr_vert_count_in;
    logic [TA_W-1:0]   curr_tri_base_in;
    logic [TIDX_W-1:0] curr_tri_count_in;
    logic [TRI_W-1:0]  idx_tri_in = '0;
    vertex_t           vert_in = '0;
    transform_t        transform_in;

    raster_fetch_if #(.INST_W(INST_W)) out_if ();

    raster_fetch dut (
        .clk                (clk),
        .rst_raster_n       (rst_n),
        .start              (start),
        .num_inst           (num_inst),
        .busy               (busy),
        .done               (done),
        .inst_id_rd         (inst_id_rd),
        .vert_addr_rd       (vert_addr_rd),
        .tri_addr_rd        (tri_addr_rd),
        .curr_vert_base_in  (curr_vert_base_in),
        .curr_vert_count_in (curr_vert_count_in),
        .curr_tri_base_in   (curr_tri_base_in),
        .curr_tri_count_in  (curr_tri_count_in),
        .idx_tri_in         (idx_tri_in),
        .vert_in            (vert_in),
        .transform_in       (transform_in),
        .out_if             (out_if),
        .oob_err            (oob_err)
    );

    always #5 clk = ~clk;

    // Geometry store: 1-cycle RAMs and a DESC_LAT=3 descriptor pipeline.
    logic [TRI_W-1:0]  tri_mem  [NT];
    vertex_t           vert_mem [NV];
    logic [VA_W-1:0]   ivb [256];
    logic [VIDX_W-1:0] ivc [256];
    logic [TA_W-1:0]   itb [256];
    logic [TIDX_W-1:0] itc [256];
    transform_t        ixf [256];
    logic [INST_W-1:0] d1 = '0, d2 = '0, d3 = '0;

    always @(posedge clk) begin
        idx_tri_in <= tri_mem[tri_addr_rd];
        vert_in    <= vert_mem[vert_addr_rd];
        d1 <= inst_id_rd;
        d2 <= d1;
        d3 <= d2;
    end

    assign curr_vert_base_in  = ivb[d3];
    assign curr_vert_count_in = ivc[d3];
    assign curr_tri_base_in   = itb[d3];
    assign curr_tri_count_in  = itc[d3];
    assign transform_in       = ixf[d3];

    int errors = 0;
    int checks = 0;

    tri_rec_t got_q[$];
    tri_rec_t exp_q[$];
    int       hs_cyc[$];
    int       vstart[$];
    logic [TA_W-1:0] addr_hist [4096];
    int       first_valid, done_cnt, done_at, stall_viol;
    logic     exp_oob;

    function automatic tri_rec_t cur_rec();
        tri_rec_t r;
        r = {out_if.out_v0, out_if.out_v1, out_if.out_v2, out_if.out_transform, out_if.out_inst_id};
        return r;
    endfunction

    function automatic vertex_t rand_vert();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    function automatic transform_t rand_xf();
        transform_t r;
        r = {$urandom, $urandom};
        return r;
    endfunction

    function automatic logic [TRI_W-1:0] pack_tri(input int a, input int b, input int c);
        return {VIDX_W'(a), VIDX_W'(b), VIDX_W'(c)};
    endfunction

    // Expected stream: every in-range triangle of every instance, in order.
    task automatic model_frame(input int n);
        exp_q.delete();
        exp_oob = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < int'(itc[i]); t++) begin
                logic [TRI_W-1:0] w;
                int a, b, c;
                tri_rec_t r;
                w = tri_mem[(int'(itb[i]) + t) % NT];
                a = int'(w[35:24]);
                b = int'(w[23:12]);
                c = int'(w[11:0]);
                if (a >= int'(ivc[i]) || b >= int'(ivc[i]) || c >= int'(ivc[i])) begin
                    exp_oob = 1'b1;
                end else begin
                    r.v0   = vert_mem[(int'(ivb[i]) + a) % NV];
                    r.v1   = vert_mem[(int'(ivb[i]) + b) % NV];
                    r.v2   = vert_mem[(int'(ivb[i]) + c) % NV];
                    r.xf   = ixf[i];
                    r.inst = INST_W'(i);
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    // Drives one frame from a negedge; cycle c is the c-th negedge after start is raised.
    task automatic run_frame(input int n, input int rdy_pct, input int hold0,
                             input int restart_at, input int budget);
        tri_rec_t prev;
        logic pv, pr;
        int hold;
        got_q.delete(); hs_cyc.delete(); vstart.delete();
        first_valid = -1; done_cnt = 0; done_at = -1; stall_viol = 0;
        pv = 1'b0; pr = 1'b1; hold = hold0; prev = '0;
        num_inst = (INST_W+1)'(n);
        start = 1'b1;
        for (int c = 1; c <= budget && done_cnt == 0; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c < 4096) addr_hist[c] = tri_addr_rd;
            if (pv && !pr && (out_if.out_valid !== 1'b1 || cur_rec() !== prev)) stall_viol++;
            if (out_if.out_valid === 1'b1 && hold > 0) begin
                out_if.out_ready = 1'b0;
                hold--;
            end else begin
                out_if.out_ready = (int'($urandom_range(99)) < rdy_pct);
            end
            if (out_if.out_valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                if (!pv) vstart.push_back(c);
                if (out_if.out_ready) begin
                    got_q.push_back(cur_rec());
                    hs_cyc.push_back(c);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            pv = (out_if.out_valid === 1'b1);
            pr = out_if.out_ready;
            prev = cur_rec();
        end
        start = 1'b0;
        out_if.out_ready = 1'b1;
    endtask

    task automatic setup_basic();
        ivb[0] = VA_W'(100); ivc[0] = VIDX_W'(4);
        itb[0] = TA_W'(10);  itc[0] = TIDX_W'(2);
        ixf[0] = rand_xf();
        for (int k = 0; k < 4; k++) vert_mem[100 + k] = rand_vert();
        tri_mem[10] = pack_tri(0, 1, 2);
        tri_mem[11] = pack_tri(2, 1, 3);
    endtask

    task automatic test_reset();
        logic [SNAP_W-1:0] snap;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        snap = {busy, done, oob_err, out_if.out_valid, inst_id_rd, tri_addr_rd, vert_addr_rd, cur_rec()};
        checks++;
        if (snap !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", snap);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        setup_basic();
        model_frame(1);
        run_frame(1, 100, 0, 0, 200);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL basic_count got=%0d exp=2", got_q.size()); end
        foreach (exp_q[k]) begin
            tri_rec_t g;
            g = (k < got_q.size()) ? got_q[k] : '0;
            checks++;
            if (g !== exp_q[k]) begin errors++; $display("FAIL basic_tri%0d got=%h exp=%h", k, g, exp_q[k]); end
        end
        checks++;
        if (first_valid !== 10) begin errors++; $display("FAIL basic_latency got=%0d exp=10", first_valid); end
        checks++;
        if (vstart.size() < 2 || vstart[1] - vstart[0] !== 6) begin
            errors++; $display("FAIL basic_rate starts=%0d exp_gap=6", vstart.size());
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 19) begin
            errors++; $display("FAIL basic_done got_cnt=%0d at=%0d exp_cnt=1 at=19", done_cnt, done_at);
        end
        checks++;
        if (oob_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_flags oob=%b busy=%b exp=0,0", oob_err, busy);
        end
    endtask

    task automatic test_backpressure();
        setup_basic();
        model_frame(1);
        run_frame(1, 100, 5, 0, 200);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL bp_count got=%0d exp=2", got_q.size()); end
        foreach (exp_q[k]) begin
            tri_rec_t g;
            g = (k < got_q.size()) ? got_q[k] : '0;
            checks++;
            if (g !== exp_q[k]) begin errors++; $display("FAIL bp_tri%0d got=%h exp=%h", k, g, exp_q[k]); end
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
        checks++;
        if (hs_cyc.size() < 1 || hs_cyc[0] !== 15) begin
            errors++; $display("FAIL bp_hs_cycle got=%0d exp=15", (hs_cyc.size() > 0) ? hs_cyc[0] : -1);
        end
        checks++;
        if (vstart.size() < 2 || vstart[1] !== 21) begin
            errors++; $display("FAIL bp_second_valid got=%0d exp=21", (vstart.size() > 1) ? vstart[1] : -1);
        end
    endtask

    task automatic test_skip_empty();
        ivb[0] = VA_W'(200); ivc[0] = VIDX_W'(3); itb[0] = TA_W'(20); itc[0] = TIDX_W'(1); ixf[0] = rand_xf();
        ivb[1] = VA_W'(250); ivc[1] = VIDX_W'(3); itb[1] = TA_W'(25); itc[1] = TIDX_W'(0); ixf[1] = rand_xf();
        ivb[2] = VA_W'(300); ivc[2] = VIDX_W'(3); itb[2] = TA_W'(30); itc[2] = TIDX_W'(2); ixf[2] = rand_xf();
        for (int k = 0; k < 3; k++) begin
            vert_mem[200 + k] = rand_vert();
            vert_mem[250 + k] = rand_vert();
            vert_mem[300 + k] = rand_vert();
        end
        tri_mem[20] = pack_tri(2, 0, 1);
        tri_mem[25] = pack_tri(0, 1, 2);
        tri_mem[30] = pack_tri(1, 2, 0);
        tri_mem[31] = pack_tri(0, 0, 2);
        model_frame(3);
        run_frame(3, 100, 0, 0, 300);
        checks++;
        if (got_q.size() !== 3) begin errors++; $display("FAIL skip_count got=%0d exp=3", got_q.size()); end
        foreach (exp_q[k]) begin
            tri_rec_t g;
            g = (k < got_q.size()) ? got_q[k] : '0;
            checks++;
            if (g !== exp_q[k]) begin errors++; $display("FAIL skip_tri%0d got=%h exp=%h", k, g, exp_q[k]); end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL skip_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_oob();
        ivb[0] = VA_W'(400); ivc[0] = VIDX_W'(4); itb[0] = TA_W'(40); itc[0] = TIDX_W'(3); ixf[0] = rand_xf();
        for (int k = 0; k < 6; k++) vert_mem[400 + k] = rand_vert();
        tri_mem[40] = pack_tri(0, 1, 2);
        tri_mem[41] = pack_tri(1, 5, 2);
        tri_mem[42] = pack_tri(3, 2, 1);
        model_frame(1);
        run_frame(1, 100, 0, 0, 300);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL oob_count got=%0d exp=2", got_q.size()); end
        foreach (exp_q[k]) begin
            tri_rec_t g;
            g = (k < got_q.size()) ? got_q[k] : '0;
            checks++;
            if (g !== exp_q[k]) begin errors++; $display("FAIL oob_tri%0d got=%h exp=%h", k, g, exp_q[k]); end
        end
        checks++;
        if (oob_err !== exp_oob) begin errors++; $display("FAIL oob_flag got=%b exp=%b", oob_err, exp_oob); end
    endtask

    task automatic test_empty_frame();
        run_frame(0, 100, 0, 0, 20);
        checks++;
        if (done_at !== 2) begin errors++; $display("FAIL empty_done_at got=%0d exp=2", done_at); end
        checks++;
        if (first_valid !== -1) begin errors++; $display("FAIL empty_valid got=%0d exp=-1", first_valid); end
        checks++;
        if (oob_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL empty_flags oob=%b busy=%b exp=0,0", oob_err, busy);
        end
    endtask

    task automatic test_start_ignored();
        setup_basic();
        model_frame(1);
        run_frame(1, 100, 0, 12, 200);
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL restart_count got=%0d exp=2", got_q.size()); end
        foreach (exp_q[k]) begin
            tri_rec_t g;
            g = (k < got_q.size()) ? got_q[k] : '0;
            checks++;
            if (g !== exp_q[k]) begin errors++; $display("FAIL restart_tri%0d got=%h exp=%h", k, g, exp_q[k]); end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 19) begin
            errors++; $display("FAIL restart_done got_cnt=%0d at=%0d exp_cnt=1 at=19", done_cnt, done_at);
        end
    endtask

    task automatic test_wrap();
        ivb[0] = VA_W'(8190); ivc[0] = VIDX_W'(4); itb[0] = TA_W'(8191); itc[0] = TIDX_W'(2); ixf[0] = rand_xf();
        vert_mem[8190] = rand_vert(); vert_mem[8191] = rand_vert();
        vert_mem[0]    = rand_vert(); vert_mem[1]    = rand_vert();
        tri_mem[8191] = pack_tri(0, 1, 2);
        tri_mem[0]    = pack_tri(3, 2, 1);
        model_frame(1);
        run_frame(1, 100, 0, 0, 200);
        foreach (exp_q[k]) begin
            tri_rec_t g;
            g = (k < got_q.size()) ? got_q[k] : '0;
            checks++;
            if (g !== exp_q[k]) begin errors++; $display("FAIL wrap_tri%0d got=%h exp=%h", k, g, exp_q[k]); end
        end
        checks++;
        if (vstart.size() < 2 || addr_hist[vstart[0] - 5] !== TA_W'(8191) || addr_hist[vstart[1] - 5] !== TA_W'(0)) begin
            errors++;
            $display("FAIL wrap_tri_addr got_starts=%0d a0=%0d a1=%0d exp=8191,0", vstart.size(),
                     (vstart.size() > 0) ? addr_hist[vstart[0] - 5] : 0,
                     (vstart.size() > 1) ? addr_hist[vstart[1] - 5] : 0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [SNAP_W-1:0] snap;
        int seen;
        setup_basic();
        run_frame(1, 100, 0, 0, 7);
        rst_n = 1'b0;
        #1;
        snap = {busy, done, oob_err, out_if.out_valid, inst_id_rd, tri_addr_rd, vert_addr_rd, cur_rec()};
        checks++;
        if (snap !== '0) begin errors++; $display("FAIL midreset_outputs got=%h exp=0", snap); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || out_if.out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_idle got=%0d active cycles exp=0", seen); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            n = int'($urandom_range(4, 1));
            for (int i = 0; i < n; i++) begin
                ivb[i] = VA_W'($urandom);
                ivc[i] = VIDX_W'($urandom_range(8, 1));
                itb[i] = TA_W'($urandom);
                itc[i] = TIDX_W'($urandom_range(4, 0));
                ixf[i] = rand_xf();
                for (int k = 0; k < 8; k++) vert_mem[(int'(ivb[i]) + k) % NV] = rand_vert();
                for (int t = 0; t < int'(itc[i]); t++) begin
                    tri_mem[(int'(itb[i]) + t) % NT] = pack_tri(int'($urandom_range(int'(ivc[i]))),
                                                                int'($urandom_range(int'(ivc[i]))),
                                                                int'($urandom_range(int'(ivc[i]))));
                end
            end
            model_frame(n);
            run_frame(n, 70, 0, 0, 3000);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) begin
                tri_rec_t g;
                g = (k < got_q.size()) ? got_q[k] : '0;
                checks++;
                if (g !== exp_q[k]) begin errors++; $display("FAIL rand%0d_tri%0d got=%h exp=%h", it, k, g, exp_q[k]); end
            end
            checks++;
            if (oob_err !== exp_oob || done_cnt !== 1 || stall_viol !== 0) begin
                errors++;
                $display("FAIL rand%0d_status oob=%b done=%0d unstable=%0d exp=%b,1,0", it, oob_err, done_cnt, stall_viol, exp_oob);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NT); i++) tri_mem[i] = '0;
        for (int i = 0; i < int'(NV); i++) vert_mem[i] = '0;
        for (int i = 0; i < 256; i++) begin
            ivb[i] = '0; ivc[i] = '0; itb[i] = '0; itc[i] = '0; ixf[i] = '0;
        end
        out_if.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_skip_empty();
        test_oob();
        test_empty_frame();
        test_start_ignored();
        test_wrap();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/raster_fetch.md
# raster_fetch

Frame-driver read engine on the `clk` domain that walks the geometry store and issues assembled triangles to the rasterizer. On `start` it iterates instance IDs `0..num_inst-1`, reads each instance's transform and vertex/triangle descriptors, and walks that instance's triangle buffer. For every triangle it fetches the three referenced vertices and presents them, with the instance transform, on a valid/ready stream. It is the read-side counterpart of the SPI-fed geometry writer.

## Interface
Parameters:
- `MAX_VERT`, 8192, vertex RAM depth; `VERT_ADDR_W = $clog2(MAX_VERT)`.
- `MAX_TRI`, 8192, triangle RAM depth; `TRI_ADDR_W = $clog2(MAX_TRI)`.
- `MAX_INST`, 256, instance slots; `INST_W = $clog2(MAX_INST)`.
- `MAX_VERT_CNT`, 4096, vertices per buffer; `VIDX_W = $clog2(MAX_VERT_CNT)`.
- `MAX_TRI_CNT`, 4096, triangles per buffer; `TIDX_W = $clog2(MAX_TRI_CNT)`.
- `TRI_W`, `3*VIDX_W`, packed index triple.
- `DESC_LAT`, 3, cycles from `inst_id_rd` change to valid descriptor inputs.

Ports:
- `clk` in 1: raster clock.
- `rst_raster_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin frame (single-cycle pulse).
- `num_inst` in INST_W+1: instances to walk.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at end of frame.
- `inst_id_rd` out INST_W: instance read address.
- `vert_addr_rd` out VERT_ADDR_W: vertex read address.
- `tri_addr_rd` out TRI_ADDR_W: triangle read address.
- `curr_vert_base_in` in VERT_ADDR_W, `curr_vert_count_in` in VIDX_W: vertex descriptor inputs.
- `curr_tri_base_in` in TRI_ADDR_W, `curr_tri_count_in` in TIDX_W: triangle descriptor inputs.
- `idx_tri_in` in TRI_W: index triple. `[3V-1:2V]`=i0, `[2V-1:V]`=i1, `[V-1:0]`=i2.
- `vert_in` in vertex_t: vertex data.
- `transform_in` in transform_t: instance transform.
- `out_valid` out 1, `out_ready` in 1: triangle stream handshake.
- `out_v0`, `out_v1`, `out_v2` out vertex_t: triangle vertices.
- `out_transform` out transform_t: transform of the triangle's instance.
- `out_inst_id` out INST_W: instance of the triangle.
- `oob_err` out 1: sticky flag, cleared on `start`.

## Operation
- All memory reads have 1-cycle latency. Address outputs are combinational from state and registers. Data inputs are sampled one cycle after their address is presented.
- States: IDLE, INST_WAIT, TRI_ADDR, V0_ADDR, V1_ADDR, V2_ADDR, V_CAP, EMIT, NEXT_INST, DONE.
- IDLE: `start` clears `inst_ctr` and `oob_err` and sets `busy`. If `num_inst==0` go to DONE, else go to INST_WAIT. `start` is ignored in every other state.
- INST_WAIT: drives `inst_id_rd=inst_ctr` for DESC_LAT+1 cycles. On the last cycle it latches the vertex base/count, triangle base/count and `transform_in`, and clears `tri_ctr`. Triangle count 0 goes to NEXT_INST, else TRI_ADDR.
- TRI_ADDR: `tri_addr_rd = tri_base + tri_ctr`, truncated to TRI_ADDR_W (wraps modulo MAX_TRI).
- V0_ADDR: latches i0..i2 from `idx_tri_in`. `vert_addr_rd = vert_base + i0`, taken combinationally from `idx_tri_in` and wrapping modulo MAX_VERT.
- V1_ADDR: captures `vert_in` into v0 and drives the i1 address.
- V2_ADDR: captures v1 and drives the i2 address.
- V_CAP: captures v2.
  - If any index is >= the vertex count: set `oob_err` and drop the triangle (no EMIT); advance as after a handshake.
  - Otherwise go to EMIT.
- EMIT: `out_valid=1`. Outputs are stable while `out_valid && !out_ready`. On the handshake, `tri_ctr++`. If `tri_ctr+1 < tri_count` go to TRI_ADDR, else NEXT_INST.
- NEXT_INST: `inst_ctr++`. If `inst_ctr+1 < num_inst` go to INST_WAIT, else DONE.
- DONE: `done=1` for one cycle, `busy=0`, return to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0, `busy` 0, `oob_err` 0. A reset mid-frame aborts at once with no `done`.
- Latency from `start` to the first `out_valid` is DESC_LAT+7 cycles (DESC_LAT+2 instance setup, +5 triangle fetch).
- Steady state with `out_ready=1`: one triangle per 6 cycles. Each stall cycle adds one.
- An empty frame (`num_inst==0`) asserts `done` 2 cycles after `start`.
- `out_valid` deasserts the cycle after the handshake.

## Test plan
- One instance: tri buffer base 10, count 2, triples (0,1,2),(2,1,3); vertex base 100 holds verts A..D; `out_ready=1` -> emits (A,B,C) then (C,B,D) with the instance transform; `done` follows; no `oob_err`.
- Backpressure: same setup, `out_ready` held 0 for 5 cycles -> outputs stable; triangle emitted exactly once.
- Three instances, middle one with triangle count 0 -> triangles only from instances 0 and 2; `out_inst_id` correct; one `done`.
- Index 5 in a 4-vertex buffer -> triangle dropped, `oob_err=1`, remaining triangles still emitted.
- Wrap: tri base 8191, count 2 -> `tri_addr_rd` 8191 then 0.
- `num_inst=0` -> `done` 2 cycles after `start`, no `out_valid`. A second `start` while busy is ignored. Reset mid-frame -> IDLE, all outputs 0.
